// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit and its neighbours.
//   - md_state_e : mult/div tracker FSM encoding
//   - MD_CNT_W   : width of the mult/div occupancy down-counter
//   - fwd_sel_e  : forwarding-mux select encoding used by the forwarding unit
//   - reg_match  : helper comparing a producer destination against a consumer
//                  source, never matching on register $0
package hazard_unit_pkg;

  localparam int MD_CNT_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  // $0 is hard-wired to zero, so a write to it can never feed a consumer.
  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard unit signal bundle.
//   Inputs to the unit : ID register specifiers and decode flags, EX load info,
//                        branch resolution.
//   Outputs of the unit: pipeline enables/bubble/flush and mult/div status.
// modport slave  : the hazard unit itself.
// modport master : the pipeline (or a bench) that drives decode/EX info.
interface hazard_unit_if;
  logic [4:0] if_id_rs;
  logic [4:0] if_id_rt;
  logic       I_type;
  logic       id_muldiv;
  logic       id_uses_hilo;
  logic [4:0] id_ex_rt;
  logic       id_ex_memread;
  logic       branch_taken;

  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       muldiv_busy;
  logic       muldiv_done;

  modport slave (
    input  if_id_rs, if_id_rt, I_type, id_muldiv, id_uses_hilo,
           id_ex_rt, id_ex_memread, branch_taken,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush,
           muldiv_busy, muldiv_done
  );

  modport master (
    output if_id_rs, if_id_rt, I_type, id_muldiv, id_uses_hilo,
           id_ex_rt, id_ex_memread, branch_taken,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush,
           muldiv_busy, muldiv_done
  );
endinterface

// File: rtl/hazard_unit_muldiv_tracker.sv
// muldiv_tracker: tracks EX occupancy of a multi-cycle mult/div.
//   clk, rst_n : clock, synchronous active-low reset
//   launch     : a mult/div leaves ID this cycle (only honoured in IDLE)
//   busy       : high exactly while the FSM is in MD_BUSY
//   done       : one-cycle registered pulse in the cycle after the last busy cycle
// The launch cycle itself counts as the first occupancy cycle, so MD_BUSY
// lasts MULDIV_CYCLES-1 cycles.
module muldiv_tracker
  import hazard_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic launch,
  output logic busy,
  output logic done
);

  localparam logic [MD_CNT_W-1:0] CNT_INIT = MD_CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d  = MD_BUSY;
          md_cnt_d = CNT_INIT;
        end
      end
      MD_BUSY: begin
        md_cnt_d = md_cnt_q - CNT_ONE;
        if (md_cnt_q == CNT_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      md_cnt_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == MD_BUSY);
  assign done = done_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline stall/flush control.
//   clk, rst_n : clock, synchronous active-low reset
//   hz (slave) : ID/EX hazard inputs in, pc_write / if_id_write /
//                id_ex_bubble / if_id_flush / muldiv_busy / muldiv_done out
// Detects load-use and mult/div-busy hazards combinationally; a taken branch
// overrides any stall by flushing IF/ID and bubbling ID/EX.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_unit_if.slave  hz
);

  logic load_use;
  logic md_hazard;
  logic stall;
  logic launch;
  logic md_busy;
  logic md_done;

  logic pc_write_c;
  logic if_id_write_c;
  logic id_ex_bubble_c;
  logic if_id_flush_c;

  // rt is only a source for R-type; for I-type it is the destination.
  always_comb begin
    load_use = hz.id_ex_memread &&
               (reg_match(hz.id_ex_rt, hz.if_id_rs) ||
                (!hz.I_type && reg_match(hz.id_ex_rt, hz.if_id_rt)));
  end

  // While reset is asserted the unit behaves as if idle, so a stale MD_BUSY
  // state cannot hold the pipeline.
  assign md_hazard = rst_n && md_busy && (hz.id_muldiv || hz.id_uses_hilo);
  assign stall     = (load_use || md_hazard) && !hz.branch_taken;

  // A branch squashes an unlaunched mult/div in ID; one already in flight
  // keeps counting inside the tracker.
  assign launch = hz.id_muldiv && !stall && !hz.branch_taken;

  muldiv_tracker #(
    .MULDIV_CYCLES (MULDIV_CYCLES)
  ) u_muldiv_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .launch (launch),
    .busy   (md_busy),
    .done   (md_done)
  );

  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    id_ex_bubble_c = 1'b0;
    if_id_flush_c  = 1'b0;
    if (hz.branch_taken) begin
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
    end else if (stall) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      id_ex_bubble_c = 1'b1;
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.if_id_write  = if_id_write_c;
  assign hz.id_ex_bubble = id_ex_bubble_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.muldiv_busy  = md_busy;
  assign hz.muldiv_done  = md_done;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (MULDIV_CYCLES = 4).
// Stimulus drives one vector per cycle just after the rising edge and pushes
// the hand-computed expected outputs; the monitor pops and compares on the
// falling edge. Expected bit order: {pc_write, if_id_write, id_ex_bubble,
// if_id_flush, muldiv_busy, muldiv_done}.
module tb_hazard_unit;

  typedef struct {
    logic [5:0] exp;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  hazard_unit_if hz();

  hazard_unit #(.MULDIV_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e = q.pop_front();
      got = {hz.pc_write, hz.if_id_write, hz.id_ex_bubble, hz.if_id_flush,
             hz.muldiv_busy, hz.muldiv_done};
      total++;
      if (got !== e.exp) begin
        bad++;
        $display("FAIL %s: got=%b expected=%b", e.name, got, e.exp);
      end
    end
  end

  task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                      input logic ity, input logic md, input logic hilo,
                      input logic [4:0] exrt, input logic mr, input logic br,
                      input logic [5:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n            = rst;
    hz.if_id_rs      = rs;
    hz.if_id_rt      = rt;
    hz.I_type        = ity;
    hz.id_muldiv     = md;
    hz.id_uses_hilo  = hilo;
    hz.id_ex_rt      = exrt;
    hz.id_ex_memread = mr;
    hz.branch_taken  = br;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin
    rst_n            = 1'b0;
    hz.if_id_rs      = '0;
    hz.if_id_rt      = '0;
    hz.I_type        = 1'b0;
    hz.id_muldiv     = 1'b0;
    hz.id_uses_hilo  = 1'b0;
    hz.id_ex_rt      = '0;
    hz.id_ex_memread = 1'b0;
    hz.branch_taken  = 1'b0;

    //    rst rs  rt  ity md hilo exrt mr br  expected   name
    step(0, 0,  0,  0,  0, 0,   0,   0, 0, 6'b110000, "reset");
    step(1, 0,  0,  0,  0, 0,   0,   0, 0, 6'b110000, "idle");
    step(1, 5,  0,  0,  0, 0,   5,   1, 0, 6'b001000, "lu_rs");
    step(1, 5,  0,  0,  0, 0,   5,   0, 0, 6'b110000, "lu_release");
    step(1, 3,  7,  0,  0, 0,   7,   1, 0, 6'b001000, "lu_rt_rtype");
    step(1, 3,  7,  1,  0, 0,   7,   1, 0, 6'b110000, "itype_rt");
    step(1, 0,  0,  0,  0, 0,   0,   1, 0, 6'b110000, "zero_reg");
    step(1, 5,  0,  0,  0, 0,   5,   1, 1, 6'b111100, "br_lu");
    step(1, 0,  0,  0,  1, 0,   0,   0, 1, 6'b111100, "br_md");
    step(1, 0,  0,  0,  0, 0,   0,   0, 0, 6'b110000, "br_md_nolaunch");
    step(1, 0,  0,  0,  1, 0,   0,   0, 0, 6'b110000, "md_launch");
    step(1, 0,  0,  0,  0, 1,   0,   0, 0, 6'b001010, "mflo_stall1");
    step(1, 0,  0,  0,  0, 1,   0,   0, 0, 6'b001010, "mflo_stall2");
    step(1, 0,  0,  0,  0, 1,   0,   0, 0, 6'b001010, "mflo_stall3");
    step(1, 0,  0,  0,  0, 1,   0,   0, 0, 6'b110001, "mflo_issue");
    step(1, 0,  0,  0,  0, 0,   0,   0, 0, 6'b110000, "md_idle");
    step(1, 0,  0,  0,  1, 0,   0,   0, 0, 6'b110000, "md_launch2");
    step(1, 0,  0,  0,  1, 0,   0,   0, 1, 6'b111110, "br_inflight");
    step(1, 0,  0,  0,  1, 0,   0,   0, 0, 6'b001010, "md_stall_a");
    step(1, 0,  0,  0,  1, 0,   0,   0, 0, 6'b001010, "md_stall_b");
    step(1, 0,  0,  0,  1, 0,   0,   0, 0, 6'b110001, "md_relaunch");
    step(1, 0,  0,  0,  0, 0,   0,   0, 0, 6'b110010, "relaunch_busy");
    step(0, 0,  0,  0,  0, 1,   0,   0, 0, 6'b110010, "rst_mid");
    step(1, 0,  0,  0,  0, 1,   0,   0, 0, 6'b110000, "rst_after");
    step(1, 0,  0,  0,  0, 0,   0,   0, 0, 6'b110000, "no_done");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      total++;
      $display("FAIL drain: pending=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
